// File: rtl/rx_ftm_status_fifo.sv
// rx_ftm_status_fifo
// Captures per-frame RX status plus FTM start/end timestamps and queues each
// frame as a 4-word record in a circular buffer. The driver drains records
// through register reads. A record pops when its last word (5'h13) is read.
// Optional feature macro: RX_FTM_STATUS_TIMEOUT_EN adds an open-frame watchdog
// (parameter TIMEOUT_CYCLES) that abandons a frame which never sees its end.
module rx_ftm_status_fifo #(
   parameter int DEPTH_LOG2 = 5
`ifdef RX_FTM_STATUS_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 200000
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_pkt_start,
   input  logic                  rx_pkt_end,
   input  logic                  fcs_ok,
   input  logic [15:0]           pkt_len,
   input  logic [47:0]           ftm_time,
   input  logic                  slv_reg_rden,
   input  logic [4:0]            axi_araddr_core,
   output logic [31:0]           rx_status_out0,
   output logic [31:0]           rx_status_out1,
   output logic [31:0]           rx_status_out2,
   output logic [31:0]           rx_status_out3,
   output logic [DEPTH_LOG2:0]   rec_count
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_OPEN = 1'b1
   } cap_state_t;

   cap_state_t              state_r;
   cap_state_t              state_nxt_s;
   logic [47:0]             ts_start_r;
   logic [6:0]              drop_cnt_r;
   logic [7:0]              abort_cnt_r;
   logic [DEPTH_LOG2-1:0]   wr_ptr_r;
   logic [DEPTH_LOG2-1:0]   rd_ptr_r;
   logic [DEPTH_LOG2:0]     rec_count_r;
   logic [127:0]            mem_r [DEPTH];

   logic                    commit_s;
   logic                    restart_s;
   logic                    timeout_s;
   logic                    pop_s;
   logic                    full_s;
   logic                    empty_s;
   logic                    accept_s;
   logic                    drop_s;
   logic [127:0]            rec_s;
   logic [127:0]            head_s;

`ifdef RX_FTM_STATUS_TIMEOUT_EN
   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
   logic [WD_W-1:0]         wd_cnt_r;
`endif

   // Count only reaches DEPTH when every slot is occupied, so its MSB is the full flag.
   assign full_s   = rec_count_r[DEPTH_LOG2];
   assign empty_s  = (rec_count_r == {(DEPTH_LOG2+1){1'b0}});
   assign pop_s    = slv_reg_rden && (axi_araddr_core == 5'h13) && !empty_s;
   // A pop in the same cycle frees a slot, so a commit at full is still accepted.
   assign accept_s = commit_s && (!full_s || pop_s);
   assign drop_s   = commit_s && !accept_s;
   assign rec_s    = {fcs_ok, drop_cnt_r, abort_cnt_r, pkt_len,
                      16'h0000, ts_start_r[47:32],
                      ts_start_r[31:0],
                      ftm_time[31:0]};
   assign head_s   = mem_r[rd_ptr_r];

   assign rx_status_out0 = empty_s ? 32'hFFFF_FFFF : head_s[127:96];
   assign rx_status_out1 = empty_s ? 32'h0000_0000 : head_s[95:64];
   assign rx_status_out2 = empty_s ? 32'h0000_0000 : head_s[63:32];
   assign rx_status_out3 = empty_s ? 32'h0000_0000 : head_s[31:0];
   assign rec_count      = rec_count_r;

   // Capture FSM next state and frame events (commit / restart / timeout).
   always_comb begin
      state_nxt_s = state_r;
      commit_s    = 1'b0;
      restart_s   = 1'b0;
      timeout_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (rx_pkt_start) begin
               state_nxt_s = ST_OPEN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_OPEN: begin
            if (rx_pkt_end) begin
               commit_s    = 1'b1;
               state_nxt_s = rx_pkt_start ? ST_OPEN : ST_IDLE;
            end else if (rx_pkt_start) begin
               restart_s   = 1'b1;
               state_nxt_s = ST_OPEN;
`ifdef RX_FTM_STATUS_TIMEOUT_EN
            end else if (wd_cnt_r == WD_LIMIT) begin
               timeout_s   = 1'b1;
               state_nxt_s = ST_IDLE;
`endif
            end else begin
               state_nxt_s = ST_OPEN;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // FSM state register and start-timestamp latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         ts_start_r <= 48'h0;
      end else begin
         state_r <= state_nxt_s;
         if (rx_pkt_start) begin
            ts_start_r <= ftm_time;
         end
      end
   end

`ifdef RX_FTM_STATUS_TIMEOUT_EN
   // Watchdog: restarts on every frame start, counts while a frame is open.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else if (rx_pkt_start || (state_r != ST_OPEN)) begin
         wd_cnt_r <= {WD_W{1'b0}};
      end else begin
         wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
   end
`endif

   // Drop/abort counters: saturate on events, clear when they are reported in a record.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_r  <= 7'd0;
         abort_cnt_r <= 8'd0;
      end else if (accept_s) begin
         drop_cnt_r  <= 7'd0;
         abort_cnt_r <= 8'd0;
      end else begin
         if (drop_s && (drop_cnt_r != 7'h7F)) begin
            drop_cnt_r <= drop_cnt_r + 7'd1;
         end
         if ((restart_s || timeout_s) && (abort_cnt_r != 8'hFF)) begin
            abort_cnt_r <= abort_cnt_r + 8'd1;
         end
      end
   end

   // Record storage; contents need no reset because the empty flag masks the outputs.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem_r[wr_ptr_r] <= rec_s;
      end
   end

   // Pointers and occupancy; a simultaneous commit and pop leaves the count unchanged.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
         rec_count_r <= {(DEPTH_LOG2+1){1'b0}};
      end else begin
         if (accept_s) begin
            wr_ptr_r <= wr_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
         end
         case ({accept_s, pop_s})
            2'b10:   rec_count_r <= rec_count_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
            2'b01:   rec_count_r <= rec_count_r - {{DEPTH_LOG2{1'b0}}, 1'b1};
            default: rec_count_r <= rec_count_r;
         endcase
      end
   end

endmodule

// File: doc/rx_ftm_status_fifo.md
# rx_ftm_status_fifo

Receive-side counterpart of the TX status path. Captures per-frame RX status and FTM hardware timestamps (frame start, frame end) from the receive pipeline. Queues each frame as one 4-word record in an internal circular buffer. The driver drains records through AXI slave register reads, and a record is popped atomically when its last word is read.

## Interface
Parameters:
- DEPTH_LOG2, default 5: buffer depth is 2^DEPTH_LOG2 records.
- TIMEOUT_CYCLES, default 200000: watchdog limit in clk cycles for an open frame. Present only with the timeout feature.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- rx_pkt_start  in  1  one-cycle pulse at PHY frame detection.
- rx_pkt_end  in  1  one-cycle pulse when FCS result is available.
- fcs_ok  in  1  FCS pass flag, qualified by rx_pkt_end.
- pkt_len  in  16  frame length in bytes, qualified by rx_pkt_end.
- ftm_time  in  48  free-running FTM timestamp counter.
- slv_reg_rden  in  1  AXI register read strobe.
- axi_araddr_core  in  5  AXI word address.
- rx_status_out0..3  out  32 each  head-record words.
- rec_count  out  DEPTH_LOG2+1  number of records held.

## Operation
Capture FSM states:
- IDLE -> OPEN on rx_pkt_start; latch ts_start <= ftm_time.
- OPEN + rx_pkt_start: restart. Re-latch ts_start, the old frame is discarded, abort_cnt is incremented (saturating at 255), and the FSM stays in OPEN.
- OPEN + rx_pkt_end: commit record, -> IDLE. If rx_pkt_end and rx_pkt_start are high in the same cycle, commit the old frame and latch the new ts_start; the FSM stays in OPEN.
- IDLE + rx_pkt_end: ignored, no record written.

Record layout:
- W0 = {fcs_ok, drop_cnt[6:0], abort_cnt[7:0], pkt_len}
- W1 = {16'd0, ts_start[47:32]}
- W2 = ts_start[31:0]
- W3 = ftm_time[31:0] sampled at the commit cycle.

Commit rules:
- Commit when buffer full: record dropped; drop_cnt increments, saturating at 127.
- Successful commit: the current drop_cnt and abort_cnt are written into W0, and both counters clear in the same cycle.

Read side:
- Outputs show the head record.
- When empty: rx_status_out0 = 32'hFFFFFFFF and rx_status_out1..3 = 0.
- Address map: 5'h10 = W0, 5'h11 = W1, 5'h12 = W2, 5'h13 = W3.
- Reads of 5'h10..5'h12 have no side effect.
- Pop: slv_reg_rden && axi_araddr_core == 5'h13 && rec_count != 0 advances the read pointer.
- Pop when empty: no effect.

Pointers and arithmetic:
- Read and write pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
- rec_count is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- Simultaneous commit and pop: both take effect and rec_count is unchanged. When full, the pop frees a slot in the same cycle, so a simultaneous commit is accepted.

## Timing
- Reset values: FSM IDLE, pointers 0, rec_count 0, drop_cnt 0, abort_cnt 0, ts_start 0.
- Outputs after reset: rx_status_out0 = FFFFFFFF, rx_status_out1..3 = 0.
- Reset mid-frame discards the open frame and all stored records.
- Capture: ts_start is ftm_time in the cycle rx_pkt_start is high.
- Commit: the record is written at the clk edge sampling rx_pkt_end. rec_count and the output words reflect it in the next cycle, giving 1-cycle latency.
- Pop: the head advances at the edge sampling the W3 read. Read data of that same cycle is the old W3, and the next record appears in the following cycle.
- Outputs are combinational from the head entry and the empty flag; there is no extra read latency.

## Configuration
- RX_FTM_STATUS_TIMEOUT_EN defined: a watchdog counter runs in OPEN and resets on entry to OPEN and on restart.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_pkt_end, the FSM returns to IDLE and abort_cnt increments (saturating); no record is written.
  - A rx_pkt_end in the same cycle as the timeout wins: the frame is committed.
- Undefined: no watchdog. OPEN persists until rx_pkt_end or rx_pkt_start. TIMEOUT_CYCLES is unused.

## Test plan
- Single frame:
  - Stimulus: ftm_time=0x0001_2345_6789 at start, rx_pkt_end with fcs_ok=1, pkt_len=100, ftm_time low=0x0000_1000.
  - Required response: out0=0x8000_0064, out1=0x0001, out2=0x2345_6789, out3=0x1000, rec_count=1.
  - Then read 5'h13: rec_count=0 and out0=FFFFFFFF.
- Overflow, DEPTH_LOG2=2:
  - Stimulus: commit 6 frames with no reads.
  - Required response: rec_count=4. Pop all 4, commit one more: its W0 bits[30:24]=2.
- Restart:
  - Stimulus: rx_pkt_start at ftm_time A, then again at B, then rx_pkt_end.
  - Required response: W1/W2 = B and W0 abort field = 1.
- Simultaneous commit and pop at full:
  - Required response: rec_count stays 2^DEPTH_LOG2, no drop counted, and FIFO order is preserved across the pointer wrap.
- Timeout (macro defined, TIMEOUT_CYCLES=50):
  - Stimulus: rx_pkt_start, no end for 60 cycles, then a full frame.
  - Required response: FSM back in IDLE at cycle 50, and the next record's abort field = 1.
  - Macro undefined: the late rx_pkt_end commits normally.
- Reset mid-frame:
  - Stimulus: rst with 3 records stored and the FSM in OPEN.
  - Required response: rec_count=0, out0=FFFFFFFF, and a subsequent rx_pkt_end is ignored.
